instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Parametrised successor to the combinational instruction ROM.
- Holds a writable instruction memory and a writable 16-entry jump-label table.
- Owns the PC and pre-decodes each fetched 8-bit instruction into format, opcode, register indices, immediate and jump location.
- Presents the result to the execute stage through a registered valid/ready handshake, with branch redirect and HALT handling.

Parameters:
- IMEM_DEPTH, 256, number of instruction words.
- PC_W, 16, width of PC, addresses and jump labels.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins fetching at start_pc.
- start_pc  in  PC_W  fetch start address.
- prog_we  in  1  instruction memory write enable.
- prog_addr  in  PC_W  instruction memory write address.
- prog_data  in  8  instruction memory write data.
- lbl_we  in  1  label table write enable.
- lbl_idx  in  4  label table entry index.
- lbl_data  in  PC_W  label table entry value.
- redirect  in  1  taken branch/jump from execute.
- redirect_pc  in  PC_W  redirect target.
- out_ready  in  1  execute stage accepts.
- out_valid  out  1  decoded instruction valid.
- pc_out  out  PC_W  address of presented instruction.
- format  out  2  C=00, I=01, M=10, X=11.
- opcode  out  4  instr[7:4].
- reg1_i, reg2_i, reg_o  out  3 each  register indices.
- imm  out  3  instr[3:1].
- imm_flag  out  1  instr[0].
- jmp_loc  out  PC_W  label lookup result.
- halted  out  1  HALT accepted.
- fault  out  1  sticky; fetch from PC >= IMEM_DEPTH.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, pc=RESET_PC.
  - All outputs 0.
  - Memory and label contents are not cleared.
- States and transitions:
  - IDLE: `start` → FETCH with pc=start_pc.
  - FETCH: normal fetch operation (below).
  - HALTED: `start` → FETCH with pc=start_pc and fault cleared. `halted` stays 1 until then.
- Writes:
  - prog_we and lbl_we take effect only in IDLE or HALTED; ignored in FETCH.
  - Memory write takes effect when prog_addr < IMEM_DEPTH.
  - Label write lands at the next edge.
- FETCH cycle rule:
  - If redirect=1: pc<=redirect_pc and out_valid<=0. Redirect overrides ready and any pending output.
  - Else if out_valid=0 or out_ready=1: register decode of imem[pc], out_valid<=1, pc_out<=pc, pc<=pc+1 (wraps modulo 2^PC_W).
  - Else: hold all outputs stable.
- Latency: first valid output 1 cycle after entering FETCH or after a redirect. Steady throughput 1 instruction/cycle.
- Out-of-range fetch: PC >= IMEM_DEPTH fetches 8'hE0 (HALT) and sets fault=1.
- Decode (registered with out_valid).
- format by opcode:
  - M: 0,1,3,5,6,7,8,A,B,C,F.
  - C: 2,4.
  - I: 9,D.
  - X: E.
- Register indices by format:
  - C: reg_o = instr[0] ? 3 : 2. reg1_i = reg2_i = 0.
  - I: reg1_i = instr[3:1], reg2_i = reg1_i+1 (3-bit wrap), reg_o = reg1_i.
  - M, opcode 5: reg1_i = {1,instr[1:0]}, reg_o = {0,instr[3:2]}, reg2_i = 0.
  - M, other opcodes: reg1_i = {0,instr[3:2]}, reg2_i = reg1_i+1, reg_o = {1,instr[1:0]}.
  - X: all register indices 0.
- jmp_loc by format:
  - C: label[instr[3:0]].
  - M: label[{2'b11,instr[1:0]}].
  - Otherwise: 0.
- HALT:
  - On presenting opcode E, stop fetching (no pc advance).
  - When accepted (out_valid & out_ready): out_valid<=0, halted<=1, state=HALTED.
  - A redirect while the HALT is pending discards it and continues fetching.
- Simultaneous events:
  - start in FETCH is ignored.
  - prog_we with start: the write completes and fetch begins the next edge.
- Reset mid-operation returns to IDLE regardless of handshake state. Program and labels persist.

Test Plan:
- Load 0:4A, 1:45, 2:94, 3:E0; start_pc=0, out_ready=1 → valid on cycles 1–4 with pc_out 0,1,2,3:
  - 4A: C, reg_o=2.
  - 45: C, reg_o=3.
  - 94: I, reg1_i=2, reg2_i=3.
  - E0: X.
  - halted=1 after acceptance.
- Backpressure: out_ready=0 for 3 cycles mid-stream → outputs and pc_out stable; no instruction skipped or duplicated on release.
- lbl[13]=0x0A0, instr 0xB1 → format M, reg1_i=0, reg2_i=1, reg_o=5, jmp_loc=0x0A0. Instr 0x21 with lbl[1]=0x30 → C, jmp_loc=0x30.
- Redirect to 10 while out_ready=0 → next cycle out_valid=0; following cycle pc_out=10.
- IMEM_DEPTH=16, start_pc=15 → pc_out 15, then pc 16 decodes as HALT with fault=1.
- prog_we during FETCH ignored (readback unchanged); rst_n low mid-stream → IDLE, out_valid=0, program intact on restart.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: writable instruction memory and jump-label table, PC, pre-decode,
// and a registered valid/ready output stage with branch redirect and HALT handling.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned PC_W       = 16,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  input  logic            lbl_we,
  input  logic [3:0]      lbl_idx,
  input  logic [PC_W-1:0] lbl_data,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [PC_W-1:0] pc_out,
  output logic [1:0]      format,
  output logic [3:0]      opcode,
  output logic [2:0]      reg1_i,
  output logic [2:0]      reg2_i,
  output logic [2:0]      reg_o,
  output logic [2:0]      imm,
  output logic            imm_flag,
  output logic [PC_W-1:0] jmp_loc,
  output logic            halted,
  output logic            fault
);

  localparam int unsigned AddrW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [PC_W:0] DepthExt = (PC_W + 1)'(IMEM_DEPTH);
  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

  localparam logic [1:0] FmtC = 2'b00;
  localparam logic [1:0] FmtI = 2'b01;
  localparam logic [1:0] FmtM = 2'b10;
  localparam logic [1:0] FmtX = 2'b11;
  localparam logic [3:0] OpHalt = 4'hE;

  typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

  logic [7:0]      imem    [IMEM_DEPTH];
  logic [PC_W-1:0] lbl_mem [16];

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic            load_dec;

  logic [1:0]      format_q;
  logic [3:0]      opcode_q;
  logic [2:0]      reg1_q, reg2_q, rego_q, imm_q;
  logic            imm_flag_q;
  logic [PC_W-1:0] jmp_q;

  logic            fetch_in_range;
  logic [7:0]      fetch_instr;
  logic [1:0]      dec_format;
  logic [3:0]      dec_opcode;
  logic [2:0]      dec_reg1, dec_reg2, dec_rego;
  logic [PC_W-1:0] dec_jmp;

  logic wr_ok;
  assign wr_ok = (state_q != StFetch);

  // Storage is deliberately outside reset so programs survive a reset.
  always_ff @(posedge clk) begin
    if (prog_we && wr_ok && ({1'b0, prog_addr} < DepthExt)) begin
      imem[prog_addr[AddrW-1:0]] <= prog_data;
    end
    if (lbl_we && wr_ok) begin
      lbl_mem[lbl_idx] <= lbl_data;
    end
  end

  // Out-of-range fetches read as HALT so the core stops cleanly.
  assign fetch_in_range = ({1'b0, pc_q} < DepthExt);
  assign fetch_instr    = fetch_in_range ? imem[pc_q[AddrW-1:0]] : 8'hE0;
  assign dec_opcode     = fetch_instr[7:4];

  always_comb begin
    dec_format = FmtM;
    dec_reg1   = '0;
    dec_reg2   = '0;
    dec_rego   = '0;
    dec_jmp    = '0;
    case (dec_opcode)
      4'h2, 4'h4: dec_format = FmtC;
      4'h9, 4'hD: dec_format = FmtI;
      4'hE:       dec_format = FmtX;
      default:    dec_format = FmtM;
    endcase
    case (dec_format)
      FmtC: begin
        dec_rego = fetch_instr[0] ? 3'd3 : 3'd2;
        dec_jmp  = lbl_mem[fetch_instr[3:0]];
      end
      FmtI: begin
        dec_reg1 = fetch_instr[3:1];
        dec_reg2 = fetch_instr[3:1] + 3'd1;
        dec_rego = fetch_instr[3:1];
      end
      FmtM: begin
        if (dec_opcode == 4'h5) begin
          dec_reg1 = {1'b1, fetch_instr[1:0]};
          dec_rego = {1'b0, fetch_instr[3:2]};
        end else begin
          dec_reg1 = {1'b0, fetch_instr[3:2]};
          dec_reg2 = {1'b0, fetch_instr[3:2]} + 3'd1;
          dec_rego = {1'b1, fetch_instr[1:0]};
        end
        dec_jmp = lbl_mem[{2'b11, fetch_instr[1:0]}];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    load_dec = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = start_pc;
        end
      end
      StFetch: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (valid_q && (opcode_q == OpHalt)) begin
          // HALT on display: no further fetch; retire only when accepted.
          if (out_ready) begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = StHalted;
          end
        end else if (!valid_q || out_ready) begin
          load_dec = 1'b1;
          valid_d  = 1'b1;
          pc_out_d = pc_q;
          if (!fetch_in_range) begin
            fault_d = 1'b1;
          end
          if (dec_opcode != OpHalt) begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      StHalted: begin
        if (start) begin
          state_d  = StFetch;
          pc_d     = start_pc;
          halted_d = 1'b0;
          fault_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= ResetPc;
      valid_q    <= 1'b0;
      pc_out_q   <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      format_q   <= '0;
      opcode_q   <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      rego_q     <= '0;
      imm_q      <= '0;
      imm_flag_q <= 1'b0;
      jmp_q      <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      if (load_dec) begin
        format_q   <= dec_format;
        opcode_q   <= dec_opcode;
        reg1_q     <= dec_reg1;
        reg2_q     <= dec_reg2;
        rego_q     <= dec_rego;
        imm_q      <= fetch_instr[3:1];
        imm_flag_q <= fetch_instr[0];
        jmp_q      <= dec_jmp;
      end
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = pc_out_q;
  assign format    = format_q;
  assign opcode    = opcode_q;
  assign reg1_i    = reg1_q;
  assign reg2_i    = reg2_q;
  assign reg_o     = rego_q;
  assign imm       = imm_q;
  assign imm_flag  = imm_flag_q;
  assign jmp_loc   = jmp_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed programs, expected decodes queued by the
// stimulus and compared by an independent monitor whenever the DUT presents an output.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] start_pc;
  logic        prog_we;
  logic [15:0] prog_addr;
  logic [7:0]  prog_data;
  logic        lbl_we;
  logic [3:0]  lbl_idx;
  logic [15:0] lbl_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] pc_out;
  logic [1:0]  format;
  logic [3:0]  opcode;
  logic [2:0]  reg1_i, reg2_i, reg_o, imm;
  logic        imm_flag;
  logic [15:0] jmp_loc;
  logic        halted;
  logic        fault;

  instr_fetch_unit #(
    .IMEM_DEPTH(16),
    .PC_W      (16),
    .RESET_PC  (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_pc   (start_pc),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .lbl_we     (lbl_we),
    .lbl_idx    (lbl_idx),
    .lbl_data   (lbl_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .pc_out     (pc_out),
    .format     (format),
    .opcode     (opcode),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .reg_o      (reg_o),
    .imm        (imm),
    .imm_flag   (imm_flag),
    .jmp_loc    (jmp_loc),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [1:0]  fmt;
    logic [3:0]  op;
    logic [2:0]  r1, r2, ro, im;
    logic        fl;
    logic [15:0] jmp;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [1:0] fmt, input logic [3:0] op,
                      input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] ro,
                      input logic [2:0] im, input logic fl, input logic [15:0] jmp,
                      input logic flt);
    exp_t e;
    e.pc = pc; e.fmt = fmt; e.op = op; e.r1 = r1; e.r2 = r2; e.ro = ro;
    e.im = im; e.fl = fl; e.jmp = jmp; e.flt = flt;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented output must match the queue head; pop on acceptance.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(pc_out), 32'hFFFF_FFFF);
      end else begin
        check("pc_out",   32'(pc_out),   32'(exp_q[0].pc));
        check("format",   32'(format),   32'(exp_q[0].fmt));
        check("opcode",   32'(opcode),   32'(exp_q[0].op));
        check("reg1_i",   32'(reg1_i),   32'(exp_q[0].r1));
        check("reg2_i",   32'(reg2_i),   32'(exp_q[0].r2));
        check("reg_o",    32'(reg_o),    32'(exp_q[0].ro));
        check("imm",      32'(imm),      32'(exp_q[0].im));
        check("imm_flag", 32'(imm_flag), 32'(exp_q[0].fl));
        check("jmp_loc",  32'(jmp_loc),  32'(exp_q[0].jmp));
        check("fault",    32'(fault),    32'(exp_q[0].flt));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [15:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic write_lbl(input logic [3:0] i, input logic [15:0] d);
    lbl_we = 1'b1; lbl_idx = i; lbl_data = d;
    tick();
    lbl_we = 1'b0;
  endtask

  task automatic start_at(input logic [15:0] pc);
    start = 1'b1; start_pc = pc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (out_valid) return;
    end
    check("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_halted(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (halted) return;
    end
    check("wait_halted_timeout", 32'(halted), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_pc = '0; prog_we = 1'b0; prog_addr = '0;
    prog_data = '0; lbl_we = 1'b0; lbl_idx = '0; lbl_data = '0; redirect = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pc_out",    32'(pc_out),    32'd0);
    check("rst_halted",    32'(halted),    32'd0);
    check("rst_fault",     32'(fault),     32'd0);
    check("rst_jmp_loc",   32'(jmp_loc),   32'd0);

    write_mem(0, 8'h4A); write_mem(1, 8'h45); write_mem(2, 8'h94); write_mem(3, 8'hE0);
    write_mem(4, 8'hB1); write_mem(5, 8'h21); write_mem(6, 8'h5C); write_mem(7, 8'hD3);
    write_mem(8, 8'hE0); write_mem(9, 8'h70); write_mem(10, 8'h3F); write_mem(11, 8'hE0);
    write_mem(14, 8'hE0); write_mem(15, 8'h2E);
    write_lbl(13, 16'h00A0); write_lbl(1, 16'h0030); write_lbl(10, 16'h1234);
    write_lbl(5, 16'h0055); write_lbl(12, 16'h0C0C); write_lbl(15, 16'h00FF);
    write_lbl(14, 16'h0E0E);

    // Basic stream with first-output latency.
    push(0, 2'b00, 4'h4, 0, 0, 2, 5, 0, 16'h1234, 0);
    push(1, 2'b00, 4'h4, 0, 0, 3, 2, 1, 16'h0055, 0);
    push(2, 2'b01, 4'h9, 2, 3, 2, 2, 0, 16'h0000, 0);
    push(3, 2'b11, 4'hE, 0, 0, 0, 0, 0, 16'h0000, 0);
    out_ready = 1'b1;
    start_at(0);
    check("lat_valid_low", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid_high", 32'(out_valid), 32'd1);
    check("lat_pc_out", 32'(pc_out), 32'd0);
    wait_halted(20);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_valid_after_halt", 32'(out_valid), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure, plus a program write during FETCH that must be dropped.
    push(4, 2'b10, 4'hB, 0, 1, 5, 0, 1, 16'h00A0, 0);
    push(5, 2'b00, 4'h2, 0, 0, 3, 0, 1, 16'h0030, 0);
    push(6, 2'b10, 4'h5, 4, 0, 3, 6, 0, 16'h0C0C, 0);
    push(7, 2'b01, 4'hD, 1, 2, 1, 1, 1, 16'h0000, 0);
    push(8, 2'b11, 4'hE, 0, 0, 0, 0, 0, 16'h0000, 0);
    start_at(4);
    check("restart_clears_halted", 32'(halted), 32'd0);
    write_mem(8, 8'h4A);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    wait_halted(20);
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while stalled discards the presented instruction.
    push(9, 2'b10, 4'h7, 0, 1, 4, 0, 0, 16'h0C0C, 0);
    push(10, 2'b10, 4'h3, 3, 4, 7, 7, 1, 16'h00FF, 0);
    push(11, 2'b11, 4'hE, 0, 0, 0, 0, 0, 16'h0000, 0);
    out_ready = 1'b0;
    start_at(9);
    wait_valid(10);
    redirect = 1'b1; redirect_pc = 16'd10;
    tick();
    redirect = 1'b0;
    check("redir_valid_low", 32'(out_valid), 32'd0);
    void'(exp_q.pop_front());
    tick();
    check("redir_valid_high", 32'(out_valid), 32'd1);
    check("redir_pc_out", 32'(pc_out), 32'd10);
    out_ready = 1'b1;
    wait_halted(20);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream, then the program must still be intact.
    push(0, 2'b00, 4'h4, 0, 0, 2, 5, 0, 16'h1234, 0);
    out_ready = 1'b0;
    start_at(0);
    wait_valid(10);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_pc_out", 32'(pc_out), 32'd0);
    void'(exp_q.pop_front());
    rst_n = 1'b1;
    push(0, 2'b00, 4'h4, 0, 0, 2, 5, 0, 16'h1234, 0);
    push(1, 2'b00, 4'h4, 0, 0, 3, 2, 1, 16'h0055, 0);
    push(2, 2'b01, 4'h9, 2, 3, 2, 2, 0, 16'h0000, 0);
    push(3, 2'b11, 4'hE, 0, 0, 0, 0, 0, 16'h0000, 0);
    out_ready = 1'b1;
    start_at(0);
    wait_halted(20);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Program write coinciding with start lands before the first fetch.
    push(13, 2'b00, 4'h2, 0, 0, 3, 0, 1, 16'h0030, 0);
    push(14, 2'b11, 4'hE, 0, 0, 0, 0, 0, 16'h0000, 0);
    prog_we = 1'b1; prog_addr = 16'd13; prog_data = 8'h21;
    start_at(13);
    prog_we = 1'b0;
    wait_halted(20);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Running off the end of memory fetches HALT and raises fault.
    push(15, 2'b00, 4'h2, 0, 0, 2, 7, 0, 16'h0E0E, 0);
    push(16, 2'b11, 4'hE, 0, 0, 0, 0, 0, 16'h0000, 1);
    start_at(15);
    wait_halted(20);
    check("oor_fault", 32'(fault), 32'd1);
    check("oor_halted", 32'(halted), 32'd1);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
    start_at(0);
    check("restart_clears_fault", 32'(fault), 32'd0);
    check("restart_halted_low", 32'(halted), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
